// File: rtl/decode_trap_if.sv
// Decode-stage bus: fetch-side instruction/IRQ/CSR inputs, regfile read
// ports and the decoded bundle toward execute.
interface decode_trap_if #(
  parameter int NUM_IRQ = 4
);
  logic               i_EN;
  logic               i_INSTRUCTION_VALID;
  logic [31:0]        i_INSTRUCTION;
  logic [NUM_IRQ-1:0] i_IRQ;
  logic [NUM_IRQ-1:0] i_IRQ_MASK;
  logic [31:0]        i_MTVEC;
  logic [31:0]        i_MEPC;
  logic [4:0]         o_RS1_PTR;
  logic [4:0]         o_RS2_PTR;
  logic [31:0]        i_RS1;
  logic [31:0]        i_RS2;
  logic [31:0]        o_PC;
  logic [7:0]         o_CORE_STATE;
  logic               o_STALL;
  logic               o_TRAP;
  logic [31:0]        o_TRAP_CAUSE;
  logic [31:0]        o_TRAP_EPC;
  logic               o_VALID;
  logic [7:0]         o_CTRL;
  logic               o_LUI;
  logic               o_AUIPC;
  logic [2:0]         o_FUNCT3;
  logic [6:0]         o_FUNCT7;
  logic [4:0]         o_RD_PTR;
  logic [31:0]        o_RS1;
  logic [31:0]        o_RS2;
  logic [31:0]        o_IMM_VAL;
  logic [31:0]        o_PC_PIPELINE;
  logic [31:0]        o_INSTRUCTION;

  // environment side (fetch, regfile, CSR unit, execute)
  modport master (
    output i_EN, i_INSTRUCTION_VALID, i_INSTRUCTION, i_IRQ, i_IRQ_MASK,
           i_MTVEC, i_MEPC, i_RS1, i_RS2,
    input  o_RS1_PTR, o_RS2_PTR, o_PC, o_CORE_STATE, o_STALL, o_TRAP,
           o_TRAP_CAUSE, o_TRAP_EPC, o_VALID, o_CTRL, o_LUI, o_AUIPC,
           o_FUNCT3, o_FUNCT7, o_RD_PTR, o_RS1, o_RS2, o_IMM_VAL,
           o_PC_PIPELINE, o_INSTRUCTION
  );

  // decode stage side
  modport slave (
    input  i_EN, i_INSTRUCTION_VALID, i_INSTRUCTION, i_IRQ, i_IRQ_MASK,
           i_MTVEC, i_MEPC, i_RS1, i_RS2,
    output o_RS1_PTR, o_RS2_PTR, o_PC, o_CORE_STATE, o_STALL, o_TRAP,
           o_TRAP_CAUSE, o_TRAP_EPC, o_VALID, o_CTRL, o_LUI, o_AUIPC,
           o_FUNCT3, o_FUNCT7, o_RD_PTR, o_RS1, o_RS2, o_IMM_VAL,
           o_PC_PIPELINE, o_INSTRUCTION
  );
endinterface

// File: rtl/decode_trap.sv
// RV32 decode stage with PC/privilege ownership, maskable prioritized
// interrupts, vectored trap entry, illegal/ECALL exceptions, RV32E register
// range checks and a one-cycle load-use bubble.
module decode_trap #(
  parameter logic [31:0] RESET_VECTOR = 32'h80000000,
  parameter int          NUM_IRQ      = 4,
  parameter int          RF_DEPTH     = 32,
  parameter bit          VECTORED     = 1'b1
) (
  input logic         i_CLK,
  input logic         i_RSTn,
  decode_trap_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSTR_ECALL = 32'h00000073;
  localparam logic [31:0] INSTR_MRET  = 32'h30200073;
  localparam logic [31:0] INSTR_WFI   = 32'h10500073;
  localparam logic [31:0] INSTR_NOP   = 32'h00000013;

  // o_CTRL bit map
  localparam logic [7:0] C_ALU_BR = 8'h01;  // ALU_OP 01: branch compare
  localparam logic [7:0] C_ALU_OP = 8'h02;  // ALU_OP 10: funct3/funct7 ALU
  localparam logic [7:0] C_REG_WE = 8'h04;
  localparam logic [7:0] C_MEM_WE = 8'h08;
  localparam logic [7:0] C_MEM_RE = 8'h10;
  localparam logic [7:0] C_IMM    = 8'h20;
  localparam logic [7:0] C_JAL    = 8'h40;
  localparam logic [7:0] C_CSR    = 8'h80;

  localparam logic [5:0] RF_LIMIT = 6'(RF_DEPTH);

  typedef enum logic [7:0] {
    ST_USER    = 8'h01,
    ST_MACHINE = 8'h02,
    ST_HALT    = 8'h04
  } state_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
  } trap_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;

  logic        r_valid, r_trap, r_lui, r_auipc;
  logic [7:0]  r_ctrl;
  logic [2:0]  r_f3;
  logic [6:0]  r_f7;
  logic [4:0]  r_rd;
  logic [31:0] r_rs1, r_rs2, r_imm, r_pc_pipe, r_instr;
  trap_t       r_trap_info, w_trap_info;

  // instruction fields
  logic [31:0] w_ins;
  logic [6:0]  w_opc, w_f7;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1f, w_rs2f;
  assign w_ins  = bus.i_INSTRUCTION;
  assign w_opc  = w_ins[6:0];
  assign w_rd   = w_ins[11:7];
  assign w_f3   = w_ins[14:12];
  assign w_rs1f = w_ins[19:15];
  assign w_rs2f = w_ins[24:20];
  assign w_f7   = w_ins[31:25];

  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_imm_i = {{20{w_ins[31]}}, w_ins[31:20]};
  assign w_imm_s = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
  assign w_imm_b = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
  assign w_imm_u = {w_ins[31:12], 12'b0};
  assign w_imm_j = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};

  function automatic logic f_rf_bad(input logic [4:0] idx);
    return {1'b0, idx} >= RF_LIMIT;
  endfunction

  // decode controls, immediate and per-format register usage
  logic [7:0]  w_ctrl;
  logic [31:0] w_imm;
  logic        w_lui, w_auipc, w_known, w_br_bad;
  logic        w_use_rd, w_use_rs1, w_use_rs2;
  logic        w_is_ecall, w_is_mret, w_is_wfi, w_jal, w_jalr, w_branch;
  always_comb begin
    w_ctrl     = '0;
    w_imm      = w_imm_i;
    w_lui      = 1'b0;
    w_auipc    = 1'b0;
    w_known    = 1'b1;
    w_br_bad   = 1'b0;
    w_use_rd   = 1'b0;
    w_use_rs1  = 1'b0;
    w_use_rs2  = 1'b0;
    w_is_ecall = 1'b0;
    w_is_mret  = 1'b0;
    w_is_wfi   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_branch   = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_ctrl = C_IMM | C_REG_WE; w_lui = 1'b1; w_imm = w_imm_u; w_use_rd = 1'b1; end
      OPC_AUIPC: begin w_ctrl = C_IMM | C_REG_WE; w_auipc = 1'b1; w_imm = w_imm_u; w_use_rd = 1'b1; end
      OPC_JAL:   begin w_ctrl = C_JAL | C_IMM | C_REG_WE; w_imm = 32'd4; w_use_rd = 1'b1; w_jal = 1'b1; end
      OPC_JALR: begin
        w_ctrl = C_JAL | C_IMM | C_REG_WE; w_imm = 32'd4;
        w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl = C_ALU_BR; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_branch = 1'b1;
        w_br_bad = (w_f3 == 3'd2) || (w_f3 == 3'd3);
      end
      OPC_LOAD:  begin w_ctrl = C_MEM_RE | C_REG_WE | C_IMM; w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      OPC_STORE: begin w_ctrl = C_MEM_WE | C_IMM; w_imm = w_imm_s; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      OPC_IMM: begin
        w_ctrl = C_ALU_OP | C_REG_WE | C_IMM; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
        if (w_f3 == 3'd1 || w_f3 == 3'd5) w_imm = {27'b0, w_rs2f};
      end
      OPC_OP: begin
        w_ctrl = C_ALU_OP | C_REG_WE; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        if (w_f3 != 3'd0) begin
          // CSR access: rs1 field is a uimm for the immediate forms
          w_ctrl = C_CSR | C_REG_WE; w_imm = {20'b0, w_ins[31:20]};
          w_use_rd = 1'b1; w_use_rs1 = ~w_f3[2];
        end else begin
          w_is_ecall = (w_ins == INSTR_ECALL);
          w_is_mret  = (w_ins == INSTR_MRET);
          w_is_wfi   = (w_ins == INSTR_WFI);
        end
      end
      default: w_known = 1'b0;
    endcase
  end

  logic w_illegal;
  assign w_illegal = ~w_known | w_br_bad | (w_is_mret & (r_state != ST_MACHINE)) |
                     (w_use_rd & f_rf_bad(w_rd)) | (w_use_rs1 & f_rf_bad(w_rs1f)) |
                     (w_use_rs2 & f_rf_bad(w_rs2f));

  // branch condition on combinational regfile data
  logic w_br_taken;
  always_comb begin
    w_br_taken = 1'b0;
    case (w_f3)
      3'd0: w_br_taken = (bus.i_RS1 == bus.i_RS2);
      3'd1: w_br_taken = (bus.i_RS1 != bus.i_RS2);
      3'd4: w_br_taken = ($signed(bus.i_RS1) <  $signed(bus.i_RS2));
      3'd5: w_br_taken = ($signed(bus.i_RS1) >= $signed(bus.i_RS2));
      3'd6: w_br_taken = (bus.i_RS1 <  bus.i_RS2);
      3'd7: w_br_taken = (bus.i_RS1 >= bus.i_RS2);
      default: w_br_taken = 1'b0;
    endcase
  end

  // interrupt priority: lowest active index wins
  logic [NUM_IRQ-1:0] w_irq_act;
  logic [4:0]         w_irq_id;
  assign w_irq_act = bus.i_IRQ & bus.i_IRQ_MASK;
  always_comb begin
    w_irq_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (w_irq_act[i]) w_irq_id = 5'(i);
  end

  logic [31:0] w_tvec_base, w_irq_tgt;
  assign w_tvec_base = {bus.i_MTVEC[31:2], 2'b00};
  assign w_irq_tgt   = (VECTORED && bus.i_MTVEC[1:0] == 2'b01) ?
                       w_tvec_base + {25'b0, w_irq_id, 2'b00} : w_tvec_base;

  // load-use: previous bundle is a load whose rd feeds this instruction
  logic w_hz, w_stall, w_irq_pend, w_irq_take, w_exec, w_trap, w_issue;
  assign w_hz       = r_valid & r_ctrl[4] & (r_rd != 5'd0) & ((r_rd == w_rs1f) | (r_rd == w_rs2f));
  assign w_stall    = w_hz & bus.i_INSTRUCTION_VALID;
  assign w_irq_pend = (|w_irq_act) & (r_state != ST_MACHINE);
  assign w_irq_take = w_irq_pend & (bus.i_INSTRUCTION_VALID | (r_state == ST_HALT)) & ~w_stall;
  assign w_exec     = bus.i_INSTRUCTION_VALID & ~w_stall & (r_state != ST_HALT) & ~w_irq_take;

  // next PC / privilege state, trap selection
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_trap      = 1'b0;
    w_issue     = 1'b0;
    w_trap_info = '0;
    if (w_irq_take) begin
      w_trap      = 1'b1;
      w_pc_nxt    = w_irq_tgt;
      w_state_nxt = ST_MACHINE;
      w_trap_info = '{cause: {1'b1, 26'b0, w_irq_id}, epc: r_pc};
    end else if (w_exec && (w_illegal || w_is_ecall)) begin
      w_trap      = 1'b1;
      w_pc_nxt    = w_tvec_base;
      w_state_nxt = ST_MACHINE;
      w_trap_info = '{cause: (w_illegal ? 32'd2 : 32'd11), epc: r_pc};
    end else if (w_exec) begin
      w_issue = 1'b1;
      if (w_is_mret)                   w_pc_nxt = bus.i_MEPC;
      else if (w_jal)                  w_pc_nxt = r_pc + w_imm_j;
      else if (w_jalr)                 w_pc_nxt = (bus.i_RS1 + w_imm_i) & ~32'd1;
      else if (w_branch && w_br_taken) w_pc_nxt = r_pc + w_imm_b;
      else                             w_pc_nxt = r_pc + 32'd4;
      if (w_is_mret)                              w_state_nxt = ST_USER;
      else if (w_is_wfi && r_state == ST_USER)    w_state_nxt = ST_HALT;
    end
  end

  // PC and privilege state register
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_pc    <= RESET_VECTOR;
      r_state <= ST_USER;
    end else if (bus.i_EN) begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
    end
  end

  // decoded bundle toward execute and trap report toward the CSR unit
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_valid     <= 1'b0;
      r_trap      <= 1'b0;
      r_trap_info <= '0;
      r_ctrl      <= '0;
      r_lui       <= 1'b0;
      r_auipc     <= 1'b0;
      r_f3        <= '0;
      r_f7        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_pc_pipe   <= '0;
      r_instr     <= INSTR_NOP;
    end else if (bus.i_EN) begin
      r_trap  <= w_trap;
      r_valid <= w_issue;
      r_ctrl  <= w_issue ? w_ctrl : 8'h00;
      r_lui   <= w_issue & w_lui;
      r_auipc <= w_issue & w_auipc;
      if (w_trap) r_trap_info <= w_trap_info;
      if (w_issue) begin
        r_f3      <= w_f3;
        r_f7      <= w_f7;
        r_rd      <= w_rd;
        r_rs1     <= bus.i_RS1;
        r_rs2     <= bus.i_RS2;
        r_imm     <= w_imm;
        r_pc_pipe <= r_pc;
        r_instr   <= w_ins;
      end
    end
  end

  assign bus.o_RS1_PTR     = w_rs1f;
  assign bus.o_RS2_PTR     = w_rs2f;
  assign bus.o_PC          = r_pc;
  assign bus.o_CORE_STATE  = r_state;
  assign bus.o_STALL       = w_stall;
  assign bus.o_TRAP        = r_trap;
  assign bus.o_TRAP_CAUSE  = r_trap_info.cause;
  assign bus.o_TRAP_EPC    = r_trap_info.epc;
  assign bus.o_VALID       = r_valid;
  assign bus.o_CTRL        = r_ctrl;
  assign bus.o_LUI         = r_lui;
  assign bus.o_AUIPC       = r_auipc;
  assign bus.o_FUNCT3      = r_f3;
  assign bus.o_FUNCT7      = r_f7;
  assign bus.o_RD_PTR      = r_rd;
  assign bus.o_RS1         = r_rs1;
  assign bus.o_RS2         = r_rs2;
  assign bus.o_IMM_VAL     = r_imm;
  assign bus.o_PC_PIPELINE = r_pc_pipe;
  assign bus.o_INSTRUCTION = r_instr;

endmodule

// File: tb/tb_decode_trap.sv
// Scoreboard bench for decode_trap: expected PC/state/valid/trap pushed when
// an instruction is driven, popped and compared after the clock edge.
module tb_decode_trap;
  localparam logic [31:0] RV     = 32'h80000000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] ADDI5  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LW3    = 32'h00012183;  // lw x3,0(x2)
  localparam logic [31:0] ADD4   = 32'h00118233;  // add x4,x3,x1
  localparam logic [31:0] ADD17  = 32'h002088B3;  // add x17,x1,x2
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] MRET   = 32'h30200073;
  localparam logic [31:0] WFI    = 32'h10500073;
  localparam logic [31:0] BEQ16  = 32'h00108863;  // beq x1,x1,+16
  localparam logic [31:0] BLT16  = 32'h00114863;  // blt x2,x1,+16
  localparam logic [31:0] JAL8   = 32'h008000EF;  // jal x1,+8
  localparam logic [31:0] JALR42 = 32'h04228067;  // jalr x0,0x42(x5)
  localparam logic [7:0]  U = 8'h01, M = 8'h02, H = 8'h04;

  logic clk = 1'b0, rst_n = 1'b0;
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  decode_trap_if #(.NUM_IRQ(4)) bus();
  decode_trap #(.RESET_VECTOR(RV), .NUM_IRQ(4), .RF_DEPTH(16), .VECTORED(1'b1)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .bus(bus)
  );

  // register file model: xN holds N
  assign bus.i_RS1 = {27'b0, bus.o_RS1_PTR};
  assign bus.i_RS2 = {27'b0, bus.o_RS2_PTR};

  typedef struct {
    logic v; logic [31:0] ins; logic [3:0] irq; logic [31:0] mepc;
    logic [31:0] pc; logic [7:0] st; logic vld; logic trap; logic [31:0] cause; logic [31:0] epc;
  } stim_t;
  typedef struct {
    logic [31:0] pc; logic [7:0] st; logic vld; logic trap; logic [31:0] cause; logic [31:0] epc;
  } exp_t;
  exp_t sbq[$];

  function automatic stim_t S(input logic v, input logic [31:0] ins, input logic [3:0] irq,
                              input logic [31:0] mepc, input logic [31:0] pc, input logic [7:0] st,
                              input logic vld, input logic trap, input logic [31:0] cause,
                              input logic [31:0] epc);
    S = '{v, ins, irq, mepc, pc, st, vld, trap, cause, epc};
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    bus.i_INSTRUCTION_VALID = s.v;
    bus.i_INSTRUCTION       = s.ins;
    bus.i_IRQ               = s.irq;
    bus.i_MEPC              = s.mepc;
    sbq.push_back('{s.pc, s.st, s.vld, s.trap, s.cause, s.epc});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({bus.o_PC, bus.o_CORE_STATE, bus.o_INSTRUCTION} !== {RV, U, NOP}) begin
      n_fail++;
      $display("FAIL reset_pc_state_instr got %h/%h/%h want %h/%h/%h",
               bus.o_PC, bus.o_CORE_STATE, bus.o_INSTRUCTION, RV, U, NOP);
    end
    n_chk++;
    if ({bus.o_VALID, bus.o_TRAP, bus.o_STALL, bus.o_CTRL, bus.o_PC_PIPELINE, bus.o_TRAP_CAUSE} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_zero_outputs got vld=%b trap=%b stall=%b ctrl=%h pcp=%h cause=%h want all 0",
               bus.o_VALID, bus.o_TRAP, bus.o_STALL, bus.o_CTRL, bus.o_PC_PIPELINE, bus.o_TRAP_CAUSE);
    end
  endtask

  task automatic test_addi();
    exp_t e;
    apply(S(1'b1, ADDI5, 4'd0, 32'd0, RV + 32'd4, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tick();
    e = sbq.pop_front();
    n_chk++;
    if ({bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP} !== {e.pc, e.st, e.vld, e.trap}) begin
      n_fail++;
      $display("FAIL addi pc/st/vld/trap got %h/%h/%b/%b want %h/%h/%b/%b",
               bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP, e.pc, e.st, e.vld, e.trap);
    end
    n_chk++;
    if ({bus.o_IMM_VAL, bus.o_CTRL, bus.o_PC_PIPELINE, bus.o_RD_PTR} !== {32'd5, 8'h26, RV, 5'd1}) begin
      n_fail++;
      $display("FAIL addi_bundle imm/ctrl/pcp/rd got %h/%h/%h/%0d want 5/26/%h/1",
               bus.o_IMM_VAL, bus.o_CTRL, bus.o_PC_PIPELINE, bus.o_RD_PTR, RV);
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    apply(S(1'b1, LW3, 4'd0, 32'd0, RV + 32'h8, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tick();
    e = sbq.pop_front();
    n_chk++;
    if ({bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_RD_PTR, bus.o_FUNCT3} !== {e.pc, e.vld, 8'h34, 5'd3, 3'd2}) begin
      n_fail++;
      $display("FAIL load pc/vld/ctrl/rd/f3 got %h/%b/%h/%0d/%0d want %h/%b/34/3/2",
               bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_RD_PTR, bus.o_FUNCT3, e.pc, e.vld);
    end
    apply(S(1'b1, ADD4, 4'd0, 32'd0, RV + 32'h8, U, 1'b0, 1'b0, 32'd0, 32'd0));
    #1;
    n_chk++;
    if (bus.o_STALL !== 1'b1) begin
      n_fail++; $display("FAIL stall_assert got %b want 1", bus.o_STALL);
    end
    tick();
    e = sbq.pop_front();
    n_chk++;
    if ({bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_STALL} !== {e.pc, e.vld, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL bubble pc/vld/ctrl/stall got %h/%b/%h/%b want %h/%b/00/0",
               bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_STALL, e.pc, e.vld);
    end
    apply(S(1'b1, ADD4, 4'd0, 32'd0, RV + 32'hC, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tick();
    e = sbq.pop_front();
    n_chk++;
    if ({bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_RD_PTR} !== {e.pc, e.vld, 8'h06, 5'd4}) begin
      n_fail++;
      $display("FAIL add_issue pc/vld/ctrl/rd got %h/%b/%h/%0d want %h/%b/06/4",
               bus.o_PC, bus.o_VALID, bus.o_CTRL, bus.o_RD_PTR, e.pc, e.vld);
    end
  endtask

  task automatic test_irq_mret();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(S(1'b1, NOP,  4'b0000, 32'd0,       RV + 32'h10, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, NOP,  4'b0110, 32'd0,       32'h1004,    M, 1'b0, 1'b1, 32'h80000001, RV + 32'h10));
    tbl.push_back(S(1'b1, MRET, 4'b0110, RV + 32'h10, RV + 32'h10, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, NOP,  4'b0110, 32'd0,       32'h1004,    M, 1'b0, 1'b1, 32'h80000001, RV + 32'h10));
    tbl.push_back(S(1'b1, MRET, 4'b0000, RV + 32'h10, RV + 32'h10, U, 1'b1, 1'b0, 32'd0, 32'd0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      e = sbq.pop_front();
      n_chk++;
      if ({bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP} !== {e.pc, e.st, e.vld, e.trap}) begin
        n_fail++;
        $display("FAIL irq_mret[%0d] pc/st/vld/trap got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP, e.pc, e.st, e.vld, e.trap);
      end
      if (e.trap) begin
        n_chk++;
        if ({bus.o_TRAP_CAUSE, bus.o_TRAP_EPC} !== {e.cause, e.epc}) begin
          n_fail++;
          $display("FAIL irq_mret_cause[%0d] cause/epc got %h/%h want %h/%h", i,
                   bus.o_TRAP_CAUSE, bus.o_TRAP_EPC, e.cause, e.epc);
        end
      end
    end
  endtask

  task automatic test_wfi();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(S(1'b1, WFI,  4'b0000, 32'd0,       RV + 32'h14, H, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, NOP,  4'b0000, 32'd0,       RV + 32'h14, H, 1'b0, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b0, NOP,  4'b0001, 32'd0,       32'h1000,    M, 1'b0, 1'b1, 32'h80000000, RV + 32'h14));
    tbl.push_back(S(1'b1, MRET, 4'b0000, RV + 32'h14, RV + 32'h14, U, 1'b1, 1'b0, 32'd0, 32'd0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      e = sbq.pop_front();
      n_chk++;
      if ({bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP} !== {e.pc, e.st, e.vld, e.trap}) begin
        n_fail++;
        $display("FAIL wfi[%0d] pc/st/vld/trap got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP, e.pc, e.st, e.vld, e.trap);
      end
      if (e.trap) begin
        n_chk++;
        if ({bus.o_TRAP_CAUSE, bus.o_TRAP_EPC} !== {e.cause, e.epc}) begin
          n_fail++;
          $display("FAIL wfi_cause[%0d] cause/epc got %h/%h want %h/%h", i,
                   bus.o_TRAP_CAUSE, bus.o_TRAP_EPC, e.cause, e.epc);
        end
      end
    end
  endtask

  task automatic test_illegal_ecall();
    stim_t tbl[$];
    exp_t  e;
    tbl.push_back(S(1'b1, ADD17, 4'd0, 32'd0,       32'h1000,    M, 1'b0, 1'b1, 32'd2,  RV + 32'h14));
    tbl.push_back(S(1'b1, ECALL, 4'd0, 32'd0,       32'h1000,    M, 1'b0, 1'b1, 32'd11, 32'h1000));
    tbl.push_back(S(1'b1, MRET,  4'd0, RV + 32'h18, RV + 32'h18, U, 1'b1, 1'b0, 32'd0,  32'd0));
    tbl.push_back(S(1'b1, MRET,  4'd0, 32'h0BAD0000, 32'h1000,   M, 1'b0, 1'b1, 32'd2,  RV + 32'h18));
    tbl.push_back(S(1'b1, MRET,  4'd0, RV + 32'h18, RV + 32'h18, U, 1'b1, 1'b0, 32'd0,  32'd0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      e = sbq.pop_front();
      n_chk++;
      if ({bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP} !== {e.pc, e.st, e.vld, e.trap}) begin
        n_fail++;
        $display("FAIL exc[%0d] pc/st/vld/trap got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP, e.pc, e.st, e.vld, e.trap);
      end
      if (e.trap) begin
        n_chk++;
        if ({bus.o_TRAP_CAUSE, bus.o_TRAP_EPC} !== {e.cause, e.epc}) begin
          n_fail++;
          $display("FAIL exc_cause[%0d] cause/epc got %h/%h want %h/%h", i,
                   bus.o_TRAP_CAUSE, bus.o_TRAP_EPC, e.cause, e.epc);
        end
      end
    end
  endtask

  task automatic test_branch();
    stim_t tbl[$];
    exp_t  e;
    bus.i_IRQ_MASK = 4'b1110;  // line 0 masked for the NOP step
    tbl.push_back(S(1'b1, BEQ16,  4'b0000, 32'd0, RV + 32'h28, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, BLT16,  4'b0000, 32'd0, RV + 32'h2C, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, NOP,    4'b0001, 32'd0, RV + 32'h30, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, JAL8,   4'b0000, 32'd0, RV + 32'h38, U, 1'b1, 1'b0, 32'd0, 32'd0));
    tbl.push_back(S(1'b1, JALR42, 4'b0000, 32'd0, 32'h46,      U, 1'b1, 1'b0, 32'd0, 32'd0));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      tick();
      e = sbq.pop_front();
      n_chk++;
      if ({bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP} !== {e.pc, e.st, e.vld, e.trap}) begin
        n_fail++;
        $display("FAIL branch[%0d] pc/st/vld/trap got %h/%h/%b/%b want %h/%h/%b/%b", i,
                 bus.o_PC, bus.o_CORE_STATE, bus.o_VALID, bus.o_TRAP, e.pc, e.st, e.vld, e.trap);
      end
    end
    n_chk++;
    if ({bus.o_CTRL, bus.o_IMM_VAL} !== {8'h64, 32'd4}) begin
      n_fail++;
      $display("FAIL jalr_bundle ctrl/imm got %h/%h want 64/4", bus.o_CTRL, bus.o_IMM_VAL);
    end
    bus.i_IRQ_MASK = 4'b1111;
  endtask

  task automatic test_en_hold();
    @(negedge clk);
    bus.i_EN = 1'b0;
    bus.i_INSTRUCTION_VALID = 1'b1;
    bus.i_INSTRUCTION = ADDI5;
    tick();
    n_chk++;
    if ({bus.o_PC, bus.o_VALID, bus.o_CTRL} !== {32'h46, 1'b1, 8'h64}) begin
      n_fail++;
      $display("FAIL en_hold pc/vld/ctrl got %h/%b/%h want 00000046/1/64",
               bus.o_PC, bus.o_VALID, bus.o_CTRL);
    end
    bus.i_EN = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.i_INSTRUCTION = ECALL;
    bus.i_INSTRUCTION_VALID = 1'b1;
    tick();
    n_chk++;
    if ({bus.o_TRAP, bus.o_PC, bus.o_TRAP_CAUSE} !== {1'b1, 32'h1000, 32'd11}) begin
      n_fail++;
      $display("FAIL pre_reset_trap trap/pc/cause got %b/%h/%h want 1/00001000/0000000b",
               bus.o_TRAP, bus.o_PC, bus.o_TRAP_CAUSE);
    end
    @(negedge clk);
    bus.i_EN = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.o_PC, bus.o_CORE_STATE, bus.o_TRAP, bus.o_TRAP_CAUSE, bus.o_TRAP_EPC, bus.o_INSTRUCTION, bus.o_VALID}
        !== {RV, U, 1'b0, 32'd0, 32'd0, NOP, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset pc/st/trap/cause/epc/instr/vld got %h/%h/%b/%h/%h/%h/%b want %h/01/0/0/0/%h/0",
               bus.o_PC, bus.o_CORE_STATE, bus.o_TRAP, bus.o_TRAP_CAUSE, bus.o_TRAP_EPC,
               bus.o_INSTRUCTION, bus.o_VALID, RV, NOP);
    end
  endtask

  initial begin
    bus.i_EN = 1'b1;
    bus.i_INSTRUCTION_VALID = 1'b0;
    bus.i_INSTRUCTION = NOP;
    bus.i_IRQ = 4'b0000;
    bus.i_IRQ_MASK = 4'b1111;
    bus.i_MTVEC = 32'h00001001;
    bus.i_MEPC = 32'd0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_addi();
    test_load_use();
    test_irq_mret();
    test_wfi();
    test_illegal_ecall();
    test_branch();
    test_en_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop in case a wait never returns
  initial begin
    #20000;
    $display("FAIL timeout bench did not complete, got no finish want finish");
    $fatal(1);
  end
endmodule

// File: doc/decode_trap.md
Name: decode_trap

Overview:
Successor to the RV32 decode stage. It decodes one instruction per enabled cycle, resolves branches and jumps, and owns the PC and the core privilege state. It adds multi-source maskable interrupts, vectored trap entry, illegal-instruction and ECALL exceptions, RV32E register-range checking, and load-use hazard bubbling. It sits between fetch and execute; the register file is external with combinational read.

Parameters:
RESET_VECTOR, 32'h80000000, PC value after reset
NUM_IRQ, 4, number of interrupt lines (1..16); lower index has higher priority
RF_DEPTH, 32, architectural registers (32 or 16); any used index >= RF_DEPTH is illegal
VECTORED, 1, 1 enables vectored interrupt entry when i_MTVEC[1:0]==2'b01

Ports:
i_CLK  in  1  clock
i_RSTn  in  1  reset, asynchronous, active-low
i_EN  in  1  stage enable; 0 holds every register
i_INSTRUCTION_VALID  in  1  i_INSTRUCTION is valid
i_INSTRUCTION  in  32  fetched instruction
i_IRQ  in  NUM_IRQ  level interrupt requests
i_IRQ_MASK  in  NUM_IRQ  per-line enable
i_MTVEC  in  32  trap vector CSR
i_MEPC  in  32  MRET return address
o_RS1_PTR, o_RS2_PTR  out  5 each  regfile read pointers (instruction[19:15], [24:20])
i_RS1, i_RS2  in  32 each  regfile read data
o_PC  out  32  current PC (to fetch)
o_CORE_STATE  out  8  USER=8'h01, MACHINE=8'h02, HALT=8'h04
o_STALL  out  1  combinational; fetch must hold its instruction
o_TRAP  out  1  registered trap-entry pulse (CSR unit writes mcause/mepc)
o_TRAP_CAUSE  out  32  {interrupt flag, 31-bit code}
o_TRAP_EPC  out  32  PC to save in mepc
o_VALID  out  1  decoded bundle valid for execute
o_CTRL  out  8  [1:0] ALU_OP, [2] REG_WE, [3] MEM_WE, [4] MEM_RE, [5] IMM, [6] JAL, [7] CSR
o_LUI, o_AUIPC  out  1 each  upper-immediate select
o_FUNCT3 / o_FUNCT7 / o_RD_PTR  out  3/7/5  instruction fields
o_RS1, o_RS2, o_IMM_VAL  out  32 each  operands
o_PC_PIPELINE, o_INSTRUCTION  out  32 each  PC and instruction of the decoded bundle

Behaviour:
- Reset (async): o_PC=RESET_VECTOR, state USER, o_INSTRUCTION=32'h00000013; all other outputs 0.
- All sequential state updates only when i_EN=1. With i_EN=0, o_TRAP and every output hold.
- Hazard: hz = o_VALID & o_CTRL[4] & o_RD_PTR!=0 & (o_RD_PTR==rs1 field | o_RD_PTR==rs2 field). o_STALL = hz & i_INSTRUCTION_VALID.
  - On stall: PC and state hold, bubble issued (o_VALID=0, o_CTRL=0).
  - The stall clears after exactly 1 cycle.
- Interrupt pending = |(i_IRQ & i_IRQ_MASK), valid only in state USER or HALT.
  - Lowest set index k wins.
  - Taken when i_INSTRUCTION_VALID, or in HALT regardless of valid.
- Exception check order, evaluated only on a valid instruction: interrupt > illegal (code 2) > ECALL (code 11).
- Illegal conditions:
  - unknown opcode
  - BRANCH funct3 of 2 or 3
  - MRET outside MACHINE
  - register field >= RF_DEPTH among the fields the format uses
- Trap entry:
  - Target PC = {i_MTVEC[31:2],2'b00}. If VECTORED and i_MTVEC[1:0]==1 and the trap is an interrupt, add 4*k.
  - State -> MACHINE.
  - Next cycle: o_TRAP=1 for 1 cycle, o_TRAP_EPC = PC of the trapped or not-yet-executed instruction, o_TRAP_CAUSE = {1,k} or {0,code}.
  - The instruction becomes a bubble.
- Exceptions are taken in any state. Interrupts are not taken in MACHINE.
- MRET in MACHINE: PC <= i_MEPC, state -> USER.
- WFI (32'h10500073): in USER, state -> HALT and PC += 4. In MACHINE it is a NOP.
- In HALT, further instructions are bubbles and the PC holds until an interrupt arrives.
- SYSTEM opcode with funct3!=0: CSR op, o_CTRL[7]=1, REG_WE=1, o_IMM_VAL = zero-extended instruction[31:20].
- Next-PC: JAL pc+IMM_J; JALR (i_RS1+IMM_I)&~1; taken branch pc+IMM_B; otherwise pc+4.
  - Branch compares: BEQ/BNE, BLT/BGE signed, BLTU/BGEU unsigned.
  - All arithmetic is modulo 2^32.
- Immediate select:
  - LUI/AUIPC IMM_U
  - STORE IMM_S
  - JAL/JALR 32'd4 (link)
  - shifts by funct3 1/5: {27'b0, shamt}
  - otherwise sign-extended IMM_I
- PC advances only when i_EN & (i_INSTRUCTION_VALID | trap) & ~o_STALL.
- Simultaneous MRET and pending interrupt: MRET executes first; the interrupt is taken on the next valid cycle.

Test Plan:
- Reset at PC 0x80000000, then ADDI x1,x0,5 -> o_VALID=1, o_IMM_VAL=5, o_PC=0x80000004, o_CTRL[2]=1.
- LW x3,0(x2) then ADD x4,x3,x1 -> o_STALL=1 for one cycle, bubble issued, then ADD issues; o_PC advances once.
- i_MTVEC=0x1001, i_IRQ=4'b0110, mask=4'b1111 in USER at PC 0x80000010 -> o_PC=0x1004, o_TRAP_CAUSE=0x80000001, o_TRAP_EPC=0x80000010, state MACHINE; MRET with i_MEPC=0x80000010 -> PC 0x80000010, state USER.
- WFI -> state HALT; then IRQ line 0 with i_INSTRUCTION_VALID=0 -> trap taken, o_TRAP_EPC = WFI PC+4.
- RF_DEPTH=16, ADD x17,x1,x2 -> o_TRAP_CAUSE=2, o_VALID=0; ECALL -> o_TRAP_CAUSE=11.
- i_RSTn asserted mid-trap with i_EN=0 -> outputs at reset values immediately, without waiting for a clock edge.
